// File: rtl/display_pkg.sv
// Shared encodings and helpers for the time-of-day display scanner.
// Slot and edit-field codes live here so the scanner and its users agree on them.
package display_pkg;

   typedef enum logic [1:0] {
      SLOT_MIN_ONES = 2'b00,
      SLOT_MIN_TENS = 2'b01,
      SLOT_HR_ONES  = 2'b10,
      SLOT_HR_TENS  = 2'b11
   } slot_e;

   typedef enum logic [1:0] {
      EDIT_NONE     = 2'b00,
      EDIT_MINUTES  = 2'b01,
      EDIT_HOURS    = 2'b10,
      EDIT_NONE_ALT = 2'b11
   } edit_e;

   localparam int DEFAULT_REFRESH_DIV = 100000;
   localparam int DEFAULT_BLINK_DIV   = 50000000;

   typedef struct packed {
      logic [3:0] hr_tens;
      logic [3:0] hr_ones;
      logic [3:0] min_tens;
      logic [3:0] min_ones;
   } digits_t;

   function automatic logic [3:0] digit_for_slot(input digits_t d, input slot_e s);
      logic [3:0] v;
      case (s)
         SLOT_MIN_ONES: v = d.min_ones;
         SLOT_MIN_TENS: v = d.min_tens;
         SLOT_HR_ONES:  v = d.hr_ones;
         default:       v = d.hr_tens;
      endcase
      return v;
   endfunction

   // Edit blinking blanks the whole field being edited; a zero leading hour
   // is suppressed whenever blank_lead is set, independent of blinking.
   function automatic logic blank_for_slot(input slot_e s, input edit_e e, input logic phase,
                                           input logic blank_lead, input logic [3:0] hr_tens);
      logic b;
      b = 1'b0;
      case (e)
         EDIT_MINUTES: b = phase && (s == SLOT_MIN_ONES || s == SLOT_MIN_TENS);
         EDIT_HOURS:   b = phase && (s == SLOT_HR_ONES  || s == SLOT_HR_TENS);
         default:      b = 1'b0;
      endcase
      if (s == SLOT_HR_TENS && blank_lead && hr_tens == 4'd0)
         b = 1'b1;
      return b;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter; o_tc is high during the terminal-count cycle.
// The counter is sized with $clog2(DIV) and works for DIV down to 2.
module tick_divider #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic o_tc
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;

   assign o_tc = (r_cnt == CW'(DIV - 1));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (o_tc)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit multiplexed display scanner with frame-coherent digit shadowing,
// edit-field blinking, leading-zero suppression and a blinking colon dot.
module display_scan_mux
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
   parameter int BLINK_DIV   = DEFAULT_BLINK_DIV
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] min_ones,
   input  logic [3:0] min_tens,
   input  logic [3:0] hr_ones,
   input  logic [3:0] hr_tens,
   input  logic [1:0] edit_field,
   input  logic       blank_lead,
   output logic [3:0] num,
   output logic [1:0] sel,
   output logic       Dot,
   output logic       digit_blank,
   output logic       scan_tick
);

   logic       w_scan_tc;
   logic       w_blink_tc;
   digits_t    w_live;

   slot_e      r_sel;
   digits_t    r_shadow;
   logic [3:0] r_num;
   logic       r_blink_phase;
   logic       r_digit_blank;
   logic       r_scan_tick;

   slot_e      w_sel_next;
   digits_t    w_shadow_next;
   logic [3:0] w_num_next;
   logic       w_phase_next;
   logic       w_blank_next;

   tick_divider #(.DIV(REFRESH_DIV)) u_refresh_div (
      .clk   (clk),
      .rst_n (rst_n),
      .o_tc  (w_scan_tc)
   );

   tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
      .clk   (clk),
      .rst_n (rst_n),
      .o_tc  (w_blink_tc)
   );

   assign w_live = {hr_tens, hr_ones, min_tens, min_ones};

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      w_sel_next    = r_sel;
      w_shadow_next = r_shadow;
      w_num_next    = r_num;
      if (w_scan_tc) begin
         w_sel_next = slot_e'(r_sel + 2'd1);
         // Reloading only at frame start keeps all four digits from one snapshot.
         if (r_sel == SLOT_HR_TENS)
            w_shadow_next = w_live;
         w_num_next = digit_for_slot(w_shadow_next, w_sel_next);
      end
      w_phase_next = r_blink_phase ^ w_blink_tc;
      w_blank_next = blank_for_slot(w_sel_next, edit_e'(edit_field), w_phase_next,
                                    blank_lead, w_shadow_next.hr_tens);
   end

   // NOTE: the shadow digits are ordinary flops and are cleared by reset like the rest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel         <= SLOT_MIN_ONES;
         r_shadow      <= '0;
         r_num         <= 4'd0;
         r_blink_phase <= 1'b0;
         r_digit_blank <= 1'b0;
         r_scan_tick   <= 1'b0;
      end else begin
         r_sel         <= w_sel_next;
         r_shadow      <= w_shadow_next;
         r_num         <= w_num_next;
         r_blink_phase <= w_phase_next;
         r_digit_blank <= w_blank_next;
         r_scan_tick   <= w_scan_tc;
      end
   end

   assign sel         = r_sel;
   assign num         = r_num;
   assign Dot         = r_blink_phase;
   assign digit_blank = r_digit_blank;
   assign scan_tick   = r_scan_tick;

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux with REFRESH_DIV = 4, BLINK_DIV = 10.
// A cycle model feeds a scoreboard queue; directed constant checks cover key points.
module tb_display_scan_mux;

   localparam int RD = 4;
   localparam int BD = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] min_ones, min_tens, hr_ones, hr_tens;
   logic [1:0] edit_field;
   logic       blank_lead;
   logic [3:0] num;
   logic [1:0] sel;
   logic       Dot, digit_blank, scan_tick;

   always #5 clk = ~clk;

   display_scan_mux #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .min_ones    (min_ones),
      .min_tens    (min_tens),
      .hr_ones     (hr_ones),
      .hr_tens     (hr_tens),
      .edit_field  (edit_field),
      .blank_lead  (blank_lead),
      .num         (num),
      .sel         (sel),
      .Dot         (Dot),
      .digit_blank (digit_blank),
      .scan_tick   (scan_tick)
   );

   int n_checks = 0;
   int n_errors = 0;
   int k = 0;
   int seg = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (seg %0d cycle %0d): observed %0h required %0h", tag, seg, k, act, exp);
      end
   endtask

   typedef struct packed {
      logic [1:0] sel;
      logic [3:0] num;
      logic       dot;
      logic       blank;
      logic       tick;
   } obs_t;

   obs_t sb[$];

   int         m_cnt, m_bcnt;
   logic       m_phase, m_tick, m_blank;
   logic [1:0] m_sel;
   logic [3:0] m_num;
   logic [3:0] m_shadow [4];

   task automatic model_reset();
      m_cnt = 0; m_bcnt = 0; m_phase = 1'b0; m_tick = 1'b0; m_blank = 1'b0;
      m_sel = 2'd0; m_num = 4'd0;
      for (int i = 0; i < 4; i++) m_shadow[i] = 4'd0;
   endtask

   // Advance the model by one clock using the inputs the DUT just sampled.
   task automatic model_step();
      obs_t o;
      bit   tc, btc;
      tc     = (m_cnt == RD - 1);
      m_cnt  = tc ? 0 : m_cnt + 1;
      m_tick = tc;
      if (tc) begin
         if (m_sel == 2'd3) begin
            m_shadow[0] = min_ones; m_shadow[1] = min_tens;
            m_shadow[2] = hr_ones;  m_shadow[3] = hr_tens;
         end
         m_sel = m_sel + 2'd1;
         m_num = m_shadow[m_sel];
      end
      btc    = (m_bcnt == BD - 1);
      m_bcnt = btc ? 0 : m_bcnt + 1;
      if (btc) m_phase = ~m_phase;
      m_blank = 1'b0;
      if (m_phase && edit_field == 2'b01 && m_sel < 2'd2) m_blank = 1'b1;
      if (m_phase && edit_field == 2'b10 && m_sel >= 2'd2) m_blank = 1'b1;
      if (blank_lead && m_sel == 2'd3 && m_shadow[3] == 4'd0) m_blank = 1'b1;
      o.sel = m_sel; o.num = m_num; o.dot = m_phase; o.blank = m_blank; o.tick = m_tick;
      sb.push_back(o);
   endtask

   task automatic compare_sb();
      obs_t exp_o, act_o;
      check("scoreboard_depth", sb.size(), 1);
      if (sb.size() != 0) begin
         exp_o = sb.pop_front();
         act_o = {sel, num, Dot, digit_blank, scan_tick};
         check("outputs{sel,num,dot,blank,tick}", act_o, exp_o);
      end
   endtask

   task automatic apply_schedule(input int kk);
      min_ones   = (kk >= 38) ? 4'd7 : 4'd4;
      min_tens   = (kk >= 208) ? 4'hB : 4'd3;
      hr_ones    = (kk >= 208) ? 4'hF : 4'd2;
      hr_tens    = (kk >= 144 && kk < 176) ? 4'd0 : 4'd1;
      blank_lead = (kk >= 144 && kk < 208);
      if (kk >= 64 && kk < 104)       edit_field = 2'b01;
      else if (kk >= 104 && kk < 144) edit_field = 2'b10;
      else if (kk >= 208)             edit_field = 2'b11;
      else                            edit_field = 2'b00;
   endtask

   task automatic directed_checks();
      int   s;
      logic d, b;
      s = (k / 4) % 4;
      check("scan_tick_period", scan_tick, (k % 4) == 0);
      check("sel_step", sel, s);
      if (seg == 0) begin
         d = ((k / 10) % 2) == 1;
         check("dot_toggle", Dot, d);
         b = 1'b0;
         if (k >= 64 && k < 104)  b = d && (s < 2);
         if (k >= 104 && k < 144) b = d && (s >= 2);
         if (k >= 144 && k < 208) b = (s == 3) && (k < 176);
         check("digit_blank", digit_blank, b);
         case (k)
            4:   check("num_first_frame_shadow_zero", num, 4'd0);
            16:  check("num_slot00", num, 4'd4);
            20:  check("num_slot01", num, 4'd3);
            24:  check("num_slot10", num, 4'd2);
            28:  check("num_slot11", num, 4'd1);
            32:  check("num_slot00_again", num, 4'd4);
            40:  check("num_old_frame_slot10", num, 4'd2);
            44:  check("num_old_frame_slot11", num, 4'd1);
            48:  check("num_new_min_ones", num, 4'd7);
            52:  check("num_next_frame_slot01", num, 4'd3);
            212: check("num_passthrough_B", num, 4'hB);
            216: check("num_passthrough_F", num, 4'hF);
            default: ;
         endcase
      end else begin
         check("post_reset_dot", Dot, 1'b0);
         check("post_reset_num", num, 4'd0);
      end
   endtask

   task automatic do_cycle();
      k++;
      if (seg == 0) apply_schedule(k);
      @(posedge clk);
      model_step();
      #1;
      compare_sb();
      directed_checks();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sel"},   sel, 2'd0);
      check({tag, "_num"},   num, 4'd0);
      check({tag, "_dot"},   Dot, 1'b0);
      check({tag, "_blank"}, digit_blank, 1'b0);
      check({tag, "_tick"},  scan_tick, 1'b0);
   endtask

   initial begin
      apply_schedule(0);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 233; i++) do_cycle();
      check("sel_before_async_reset", sel, 2'b10);
      // Mid clock-low phase: no edge occurs between asserting reset and checking.
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      seg = 1;
      k = 0;
      for (int i = 0; i < 8; i++) do_cycle();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
